ct_vfmau_norm_10bit: RTL and testbench

CT_VFMAU_NORM_10BIT -- requirements
Module: ct_vfmau_norm_10bit

---
 rtl/ct_vfmau_norm_10bit.sv | 122 ++++++++++++
 tb/tb_ct_vfmau_norm_10bit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ct_vfmau_norm_10bit.sv
// Two-stage mantissa normalizer: S1 decodes the leading-one code into a shift limited by the
// exponent, S2 applies it. Optional code/data consistency check under VFMAU_NORM_CHECK_EN.
module ct_vfmau_norm_10bit (
    input  logic       forever_cpuclk,
    input  logic       cpurst,
    input  logic       norm_in_vld,
    output logic       norm_in_rdy,
    input  logic [9:0] norm_in_data,
    input  logic [3:0] norm_in_code,
    input  logic [7:0] norm_in_expt,
    output logic       norm_out_vld,
    input  logic       norm_out_rdy,
    output logic [9:0] norm_out_data,
    output logic [7:0] norm_out_expt,
    output logic       norm_out_zero,
    output logic       norm_out_uflow,
    output logic       norm_out_err
);

    // Handshake: a transfer happens on a rising edge where vld & rdy are both high; vld never
    // depends combinationally on rdy, and a presented result stays stable until accepted.
    logic       s1_vld_q, s2_vld_q;
    logic [9:0] s1_data_q;
    logic [7:0] s1_expt_q;
    logic [3:0] s1_shift_q;
    logic       s1_zero_q, s1_uflow_q;
    logic [9:0] out_data_q, out_data_d;
    logic [7:0] out_expt_q, out_expt_d;
    logic       out_zero_q, out_uflow_q;

    logic       s2_load, in_acc;
    logic       code_legal, req_gt_expt;
    logic [3:0] req, s1_shift_d;

    assign s2_load     = !s2_vld_q || norm_out_rdy;
    assign norm_in_rdy = !s1_vld_q || s2_load;
    assign in_acc      = norm_in_vld && norm_in_rdy;

    // A shift larger than the exponent would drive it negative, so clamp to the exponent.
    assign code_legal  = (norm_in_code >= 4'd1) && (norm_in_code <= 4'd10);
    assign req         = norm_in_code - 4'd1;
    assign req_gt_expt = {4'd0, req} > norm_in_expt;

    always_comb begin
        s1_shift_d = 4'd0;
        if (code_legal) s1_shift_d = req_gt_expt ? norm_in_expt[3:0] : req;
    end

    always_comb begin
        out_data_d = 10'd0;
        out_expt_d = 8'd0;
        if (!s1_zero_q) begin
            out_data_d = s1_data_q << s1_shift_q;
            out_expt_d = s1_expt_q - {4'd0, s1_shift_q};
        end
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            s1_vld_q    <= 1'b0;
            s1_data_q   <= 10'd0;
            s1_expt_q   <= 8'd0;
            s1_shift_q  <= 4'd0;
            s1_zero_q   <= 1'b0;
            s1_uflow_q  <= 1'b0;
            s2_vld_q    <= 1'b0;
            out_data_q  <= 10'd0;
            out_expt_q  <= 8'd0;
            out_zero_q  <= 1'b0;
            out_uflow_q <= 1'b0;
        end else begin
            if (norm_in_rdy) s1_vld_q <= norm_in_vld;
            if (in_acc) begin
                s1_data_q  <= norm_in_data;
                s1_expt_q  <= norm_in_expt;
                s1_shift_q <= s1_shift_d;
                s1_zero_q  <= !code_legal;
                s1_uflow_q <= code_legal && req_gt_expt;
            end
            if (s2_load) s2_vld_q <= s1_vld_q;
            if (s2_load && s1_vld_q) begin
                out_data_q  <= out_data_d;
                out_expt_q  <= out_expt_d;
                out_zero_q  <= s1_zero_q;
                out_uflow_q <= s1_uflow_q;
            end
        end
    end

    assign norm_out_vld   = s2_vld_q;
    assign norm_out_data  = out_data_q;
    assign norm_out_expt  = out_expt_q;
    assign norm_out_zero  = out_zero_q;
    assign norm_out_uflow = out_uflow_q;

`ifdef VFMAU_NORM_CHECK_EN
    // Highest set bit wins: ascending scan lets later (higher) bits overwrite the code.
    logic [3:0] lead_code;
    logic       s1_err_q, out_err_q;

    always_comb begin
        lead_code = 4'd0;
        for (int i = 0; i < 10; i++)
            if (norm_in_data[i]) lead_code = 4'(10 - i);
    end

    always_ff @(posedge forever_cpuclk or posedge cpurst) begin
        if (cpurst) begin
            s1_err_q  <= 1'b0;
            out_err_q <= 1'b0;
        end else begin
            if (in_acc) s1_err_q <= (lead_code != norm_in_code);
            if (s2_load && s1_vld_q) out_err_q <= s1_err_q;
        end
    end

    assign norm_out_err = out_err_q;
`else
    assign norm_out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ct_vfmau_norm_10bit.sv
// Bench for ct_vfmau_norm_10bit: directed corner cases, backpressure, reset flush and a
// randomized stream scored against an arithmetic reference model.
module tb_ct_vfmau_norm_10bit;

`ifdef VFMAU_NORM_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       norm_in_vld = 1'b0;
    logic       norm_in_rdy;
    logic [9:0] norm_in_data = '0;
    logic [3:0] norm_in_code = '0;
    logic [7:0] norm_in_expt = '0;
    logic       norm_out_vld;
    logic       norm_out_rdy = 1'b1;
    logic [9:0] norm_out_data;
    logic [7:0] norm_out_expt;
    logic       norm_out_zero, norm_out_uflow, norm_out_err;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;
    int results_seen = 0;
    int last_pop = -10;
    int streak = 0;
    logic [20:0] exp_q[$];
    logic        prev_held = 1'b0;
    logic [21:0] prev_out = '0;

    ct_vfmau_norm_10bit dut (
        .forever_cpuclk(clk),
        .cpurst        (rst),
        .norm_in_vld   (norm_in_vld),
        .norm_in_rdy   (norm_in_rdy),
        .norm_in_data  (norm_in_data),
        .norm_in_code  (norm_in_code),
        .norm_in_expt  (norm_in_expt),
        .norm_out_vld  (norm_out_vld),
        .norm_out_rdy  (norm_out_rdy),
        .norm_out_data (norm_out_data),
        .norm_out_expt (norm_out_expt),
        .norm_out_zero (norm_out_zero),
        .norm_out_uflow(norm_out_uflow),
        .norm_out_err  (norm_out_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int lead_of(input int d);
        return (d == 0) ? 0 : 11 - $clog2(d + 1);
    endfunction

    // Reference: result packed as {data[9:0], expt[7:0], zero, uflow, err}.
    function automatic logic [20:0] model(input int d, input int c, input int e);
        int req, sh, od, oe;
        bit z, u, er;
        if (c >= 1 && c <= 10) begin
            req = c - 1;
            sh  = (req < e) ? req : e;
            od  = (d * (1 << sh)) % 1024;
            oe  = e - sh;
            z   = 1'b0;
            u   = (req > e);
        end else begin
            od = 0; oe = 0; z = 1'b1; u = 1'b0;
        end
        er = CHK && (lead_of(d) != c);
        return {od[9:0], oe[7:0], z, u, er};
    endfunction

    // Scoreboard monitor: pops one expectation per accepted result, checks held outputs.
    always @(negedge clk) begin
        logic [21:0] cur;
        logic [20:0] e;
        cur = {norm_out_vld, norm_out_data, norm_out_expt, norm_out_zero, norm_out_uflow, norm_out_err};
        if (rst) begin
            prev_held = 1'b0;
        end else begin
            if (prev_held) chk("held_stable", {10'd0, cur}, {10'd0, prev_out});
            if (norm_out_vld && norm_out_rdy) begin
                results_seen++;
                streak   = (cyc == last_pop + 1) ? streak + 1 : 1;
                last_pop = cyc;
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", {11'd0, cur[20:0]}, {11'd0, e});
                end
            end
            prev_held = norm_out_vld && !norm_out_rdy;
            prev_out  = cur;
        end
    end

    task automatic send_exp(input logic [9:0] d, input logic [3:0] c, input logic [7:0] e,
                            input logic [20:0] ex);
        bit acc = 1'b0;
        int n = 0;
        norm_in_vld  = 1'b1;
        norm_in_data = d;
        norm_in_code = c;
        norm_in_expt = e;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = norm_in_rdy;
            if (acc) exp_q.push_back(ex);
            @(posedge clk); #1;
            n++;
        end
        norm_in_vld = 1'b0;
        if (!acc) chk("in_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send(input logic [9:0] d, input logic [3:0] c, input logic [7:0] e);
        send_exp(d, c, e, model(int'(d), int'(c), int'(e)));
    endtask

    task automatic send_rand();
        logic [9:0] d;
        logic [3:0] c;
        logic [7:0] e;
        d = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(0, 1023));
        c = $urandom_range(0, 1) ? 4'(lead_of(int'(d))) : 4'($urandom_range(0, 15));
        e = $urandom_range(0, 1) ? 8'($urandom_range(0, 12)) : 8'($urandom_range(0, 255));
        send(d, c, e);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        chk("drain_empty", exp_q.size(), 32'd0);
    endtask

    initial begin
        int seen0;
        bit done;

        // Reset values
        #3;
        chk("rst_out_vld", norm_out_vld, 1'b0);
        chk("rst_in_rdy", norm_in_rdy, 1'b1);
        chk("rst_outputs", {norm_out_data, norm_out_expt, norm_out_zero, norm_out_uflow, norm_out_err}, 21'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed corner cases, first one also checks 2-cycle latency
        send_exp(10'b0000100000, 4'd5, 8'd20, {10'b1000000000, 8'd16, 3'b000});
        @(negedge clk);
        chk("lat_cycle1_vld", norm_out_vld, 1'b0);
        @(negedge clk);
        chk("lat_cycle2_vld", norm_out_vld, 1'b1);
        @(posedge clk); #1;
        send_exp(10'b0000000001, 4'd10, 8'd3, {10'b0000001000, 8'd0, 3'b010});
        send_exp(10'd0, 4'd0, 8'd50, {10'd0, 8'd0, 3'b100});
        send_exp(10'd0, 4'd12, 8'd50, {10'd0, 8'd0, 2'b10, CHK});
        send_exp(10'b0100000000, 4'd4, 8'd20, {10'd0, 8'd17, 2'b00, CHK});
        send_exp(10'b0010000000, 4'd3, 8'd0, {10'b0010000000, 8'd0, 3'b010});
        send_exp(10'b0001000000, 4'd4, 8'd3, {10'b1000000000, 8'd0, 3'b000});
        send_exp(10'b1000000001, 4'd1, 8'd255, {10'b1000000001, 8'd255, 3'b000});
        drain();

        // Eight back-to-back with output always ready: consecutive results
        for (int i = 0; i < 8; i++) send_rand();
        drain();
        chk("b2b_streak", streak, 32'd8);

        // Eight back-to-back with a 3-cycle output stall mid-stream
        seen0 = results_seen;
        fork
            for (int i = 0; i < 8; i++) send_rand();
            begin
                repeat (3) @(posedge clk);
                #1 norm_out_rdy = 1'b0;
                repeat (3) @(negedge clk);
                chk("stall_in_rdy", norm_in_rdy, 1'b0);
                @(posedge clk); #1;
                norm_out_rdy = 1'b1;
            end
        join
        drain();
        chk("stall_count", results_seen - seen0, 32'd8);

        // Reset with two operands in flight
        norm_out_rdy = 1'b0;
        send(10'h155, 4'd2, 8'd9);
        send(10'h0f0, 4'd3, 8'd9);
        #2 rst = 1'b1;
        #1;
        exp_q.delete();
        chk("midrst_out_vld", norm_out_vld, 1'b0);
        chk("midrst_in_rdy", norm_in_rdy, 1'b1);
        chk("midrst_outputs", {norm_out_data, norm_out_expt, norm_out_zero, norm_out_uflow, norm_out_err}, 21'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        norm_out_rdy = 1'b1;
        seen0 = results_seen;
        repeat (5) @(posedge clk);
        #1;
        chk("no_stale_result", results_seen - seen0, 32'd0);
        send_exp(10'b0000100000, 4'd5, 8'd20, {10'b1000000000, 8'd16, 3'b000});
        @(negedge clk);
        chk("post_rst_lat1", norm_out_vld, 1'b0);
        @(negedge clk);
        chk("post_rst_lat2", norm_out_vld, 1'b1);
        @(posedge clk); #1;
        drain();

        // Randomized stream with random gaps and random backpressure
        seen0 = results_seen;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 60; i++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk); #1;
                    end
                    send_rand();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    norm_out_rdy = ($urandom_range(0, 3) != 0);
                end
                norm_out_rdy = 1'b1;
            end
        join
        drain();
        chk("rand_count", results_seen - seen0, 32'd60);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
